// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one registered-LUT constant multiplier between NUM_REQ requesters,
// returning tagged products via a 2-entry FIFO. Define MULT_SHARE_FIXED_PRIO_EN for fixed priority.

module const_multiplier #(
   parameter int CONST_FACTOR = 3,
   parameter int INPUT_WIDTH  = 10,
   parameter int OUTPUT_WIDTH = 10
) (
   input  logic                    clk,
   input  logic [INPUT_WIDTH-1:0]  data_i,
   output logic [OUTPUT_WIDTH-1:0] data_o
);
   logic [OUTPUT_WIDTH-1:0] w_lut [2**INPUT_WIDTH];
   logic [OUTPUT_WIDTH-1:0] r_lut_q;

   // Constant table of truncated products, read through a register without reset.
   for (genvar g = 0; g < 2**INPUT_WIDTH; g++) begin : g_lut
      assign w_lut[g] = OUTPUT_WIDTH'(g * CONST_FACTOR);
   end

   always_ff @(posedge clk) begin
      r_lut_q <= w_lut[data_i];
   end

   assign data_o = r_lut_q;
endmodule

module mult_share_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int CONST_FACTOR = 3,
   parameter int INPUT_WIDTH  = 10,
   parameter int OUTPUT_WIDTH = 10,
   parameter int ID_WIDTH     = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic                           rsp_valid_o,
   output logic [ID_WIDTH-1:0]            rsp_id_o,
   output logic [OUTPUT_WIDTH-1:0]        rsp_data_o,
   input  logic                           rsp_ready_i
);
   logic [NUM_REQ-1:0]      w_sel;
   logic [ID_WIDTH-1:0]     w_sel_id;
   logic                    w_found;
   logic                    w_credit_ok;
   logic                    w_accept;
   logic                    w_pop;
   logic [2:0]              w_occ;
   logic [INPUT_WIDTH-1:0]  w_operand;
   logic [OUTPUT_WIDTH-1:0] w_product;

   logic                    r_inflight;
   logic [ID_WIDTH-1:0]     r_id;
   logic [ID_WIDTH-1:0]     r_fifo_id   [2];
   logic [OUTPUT_WIDTH-1:0] r_fifo_data [2];
   logic                    r_wptr;
   logic                    r_rptr;
   logic [1:0]              r_count;

   assign rsp_valid_o = (r_count != 2'd0);
   assign rsp_id_o    = r_fifo_id[r_rptr];
   assign rsp_data_o  = r_fifo_data[r_rptr];
   assign w_pop       = rsp_valid_o && rsp_ready_i;

   // Every accepted operand is either in the multiplier register or queued, so this bounds FIFO fill.
   assign w_occ       = {2'b00, r_inflight} + {1'b0, r_count} - {2'b00, w_pop};
   assign w_credit_ok = (w_occ < 3'd2);

`ifdef MULT_SHARE_FIXED_PRIO_EN
   always_comb begin
      w_sel    = '0;
      w_sel_id = '0;
      w_found  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && req_valid_i[i]) begin
            w_found  = 1'b1;
            w_sel[i] = 1'b1;
            w_sel_id = ID_WIDTH'(i);
         end
      end
   end
`else
   logic [ID_WIDTH-1:0] r_rr_ptr;

   // Outer loop over pointer values keeps every select index a constant.
   always_comb begin
      w_sel    = '0;
      w_sel_id = '0;
      w_found  = 1'b0;
      for (int p = 0; p < NUM_REQ; p++) begin
         if (r_rr_ptr == ID_WIDTH'(p)) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
               if (!w_found && req_valid_i[(p + i) % NUM_REQ]) begin
                  w_found                     = 1'b1;
                  w_sel[(p + i) % NUM_REQ]    = 1'b1;
                  w_sel_id                    = ID_WIDTH'((p + i) % NUM_REQ);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
      end else if (w_accept) begin
         r_rr_ptr <= w_sel_id;
      end
   end
`endif

   assign req_ready_o = w_sel & {NUM_REQ{w_credit_ok && rst_n}};
   assign w_accept    = |(req_valid_i & req_ready_o);

   always_comb begin
      w_operand = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_sel_id == ID_WIDTH'(k)) begin
            w_operand = req_data_i[k*INPUT_WIDTH +: INPUT_WIDTH];
         end
      end
   end

   const_multiplier #(
      .CONST_FACTOR (CONST_FACTOR),
      .INPUT_WIDTH  (INPUT_WIDTH),
      .OUTPUT_WIDTH (OUTPUT_WIDTH)
   ) u_mult (
      .clk    (clk),
      .data_i (w_operand),
      .data_o (w_product)
   );

   // The id travels alongside the LUT register; r_inflight qualifies the push since the LUT has no reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
         r_id       <= '0;
      end else begin
         r_inflight <= w_accept;
         if (w_accept) begin
            r_id <= w_sel_id;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_fifo_id[i]   <= '0;
            r_fifo_data[i] <= '0;
         end
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (r_inflight) begin
            r_fifo_id[r_wptr]   <= r_id;
            r_fifo_data[r_wptr] <= w_product;
            r_wptr              <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter against a transaction-level model of grants and responses.

module tb_mult_share_arbiter;
   localparam int NR  = 3;
   localparam int IW  = 4;
   localparam int OW  = 5;
   localparam int CF  = 3;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req_valid_i = '0;
   logic [NR*IW-1:0] req_data_i = '0;
   logic [NR-1:0]    req_ready_o;
   logic             rsp_valid_o;
   logic [IDW-1:0]   rsp_id_o;
   logic [OW-1:0]    rsp_data_o;
   logic             rsp_ready_i = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   // Model: outstanding responses {id,data} in accept order, with the cycle each becomes visible.
   logic [IDW+OW-1:0] exp_q[$];
   int                vis_q[$];
   int                last_ptr = NR - 1;
   int                cyc = 0;

   mult_share_arbiter #(
      .NUM_REQ      (NR),
      .CONST_FACTOR (CF),
      .INPUT_WIDTH  (IW),
      .OUTPUT_WIDTH (OW)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_id_o    (rsp_id_o),
      .rsp_data_o  (rsp_data_o),
      .rsp_ready_i (rsp_ready_i)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int model_grant(input logic [NR-1:0] v, input int outstanding, input bit pop);
      if (outstanding - int'(pop) >= 2) return -1;
`ifdef MULT_SHARE_FIXED_PRIO_EN
      for (int i = 0; i < NR; i++) begin
         if (v[i]) return i;
      end
`else
      for (int i = 1; i <= NR; i++) begin
         int k;
         k = (last_ptr + i) % NR;
         if (v[k]) return k;
      end
`endif
      return -1;
   endfunction

   // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
   task automatic step(input logic [NR-1:0] v, input logic [NR*IW-1:0] d, input logic rr);
      int            g;
      bit            hv;
      bit            pop;
      logic [NR-1:0] exp_ready;
      logic [IW-1:0] opnd;
      logic [OW-1:0] prod;
      req_valid_i = v;
      req_data_i  = d;
      rsp_ready_i = rr;
      @(negedge clk);
      hv  = (exp_q.size() > 0) && (vis_q[0] <= cyc);
      pop = hv && rr;
      g   = model_grant(v, exp_q.size(), pop);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check_eq("req_ready", 32'(req_ready_o), 32'(exp_ready));
      check_eq("rsp_valid", 32'(rsp_valid_o), 32'(hv));
      if (hv) begin
         check_eq("rsp_id", 32'(rsp_id_o), 32'(exp_q[0][IDW+OW-1:OW]));
         check_eq("rsp_data", 32'(rsp_data_o), 32'(exp_q[0][OW-1:0]));
      end
      check_eq("fifo_le_2", 32'(u_dut.r_count <= 2'd2), 32'd1);
      if (pop) begin
         void'(exp_q.pop_front());
         void'(vis_q.pop_front());
      end
      if (g >= 0) begin
         opnd = d[g*IW +: IW];
         prod = OW'((int'(opnd) * CF) % (1 << OW));
         exp_q.push_back({IDW'(g), prod});
         vis_q.push_back(cyc + 2);
         last_ptr = g;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n       = 1'b0;
      req_valid_i = '1;
      rsp_ready_i = 1'b1;
      repeat (n) begin
         @(negedge clk);
         check_eq("rst_ready", 32'(req_ready_o), 32'd0);
         check_eq("rst_valid", 32'(rsp_valid_o), 32'd0);
         check_eq("rst_id", 32'(rsp_id_o), 32'd0);
         check_eq("rst_data", 32'(rsp_data_o), 32'd0);
         cyc++;
         @(posedge clk);
         #1;
      end
      exp_q.delete();
      vis_q.delete();
      last_ptr = NR - 1;
      rst_n    = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) step('0, '0, 1'b1);
   endtask

   initial begin
      #1;
      do_reset(3);

      // Single request, then truncation on another requester.
      step(3'b001, {4'd0, 4'd0, 4'd5}, 1'b1);
      idle(4);
      step(3'b010, {4'd0, 4'd15, 4'd0}, 1'b1);
      idle(4);

      // All valid, consumer always ready.
      repeat (12) step(3'b111, {4'd3, 4'd2, 4'd1}, 1'b1);
      idle(4);

      // Backpressure from idle, then release.
      repeat (6) step(3'b111, {4'd3, 4'd2, 4'd1}, 1'b0);
      repeat (10) step(3'b111, {4'd3, 4'd2, 4'd1}, 1'b1);
      idle(4);

      // Single requester continuously valid.
      repeat (8) step(3'b100, {4'd9, 4'd0, 4'd0}, 1'b1);
      idle(4);

      repeat (400) begin
         step(NR'($urandom_range(0, 7)), NR*IW'($urandom),
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      end
      idle(4);

      // Reset right after an accept: that product must never appear.
      step(3'b001, {4'd0, 4'd0, 4'd4}, 1'b1);
      do_reset(2);
      idle(6);

      repeat (200) begin
         step(NR'($urandom_range(0, 7)), NR*IW'($urandom), 1'(($urandom_range(0, 1))));
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
